// File: rtl/control_id_pipe.sv
// control_id_pipe: MIPS ID control decode and ID/EX register with load-use stall.
// Define CTRL_ILLEGAL_EN to add the registered out_illegal flag.
module control_id_pipe #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_EX   = 8,
  parameter int NB_MEM  = 9,
  parameter int NB_WB   = 2
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  input  logic [NB_DATA-1:0] in_instruction,
  input  logic               in_valid,
  input  logic               in_hold,
  input  logic               in_flush,
  output logic               out_stall,
  output logic               out_valid,
  output logic [NB_EX-1:0]   out_ex,
  output logic [NB_MEM-1:0]  out_mem,
  output logic [NB_WB-1:0]   out_wb,
  output logic [NB_ADDR-1:0] out_rs,
  output logic [NB_ADDR-1:0] out_rt,
  output logic [NB_ADDR-1:0] out_rd,
  output logic [NB_DATA-1:0] out_imm,
`ifdef CTRL_ILLEGAL_EN
  output logic               out_illegal,
`endif
  output logic [4:0]         out_shamt
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;

  localparam logic [3:0] ALU_R   = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b0111;

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [NB_ADDR-1:0] rs;
  logic [NB_ADDR-1:0] rt;
  logic [NB_ADDR-1:0] rd;
  logic [4:0]         shamt;
  logic [15:0]        imm16;

  assign op    = in_instruction[31:26];
  assign funct = in_instruction[5:0];
  assign rs    = in_instruction[21 +: NB_ADDR];
  assign rt    = in_instruction[16 +: NB_ADDR];
  assign rd    = in_instruction[11 +: NB_ADDR];
  assign shamt = in_instruction[10:6];
  assign imm16 = in_instruction[15:0];

  logic is_r, is_alui, is_ld, is_st, is_br;
  logic is_j, is_jal, zext, uses_rt;

  assign is_r    = (op == OP_R);
  assign is_alui = (op == 6'h08) | (op == 6'h09)
                 | (op == 6'h0A) | (op == 6'h0C)
                 | (op == 6'h0D) | (op == 6'h0E)
                 | (op == 6'h0F);
  assign is_ld   = (op == 6'h20) | (op == 6'h21)
                 | (op == 6'h23) | (op == 6'h24)
                 | (op == 6'h25);
  assign is_st   = (op == 6'h28) | (op == 6'h29)
                 | (op == 6'h2B);
  assign is_br   = (op == 6'h04) | (op == 6'h05);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign zext    = (op == 6'h0C) | (op == 6'h0D)
                 | (op == 6'h0E);
  assign uses_rt = is_r | is_st | is_br;

  logic       reg_dst, alu_src, shamt_sel, link;
  logic [3:0] alu_op;
  logic       mem_read, mem_write, beq, bne, jump;
  logic [1:0] size;
  logic       sign_ext;
  logic       reg_write, mem_to_reg;
  logic       kill;

`ifdef CTRL_ILLEGAL_EN
  logic d_bad;
  logic r_ok;

  assign r_ok = (funct == 6'h00) | (funct == 6'h02)
              | (funct == 6'h03) | (funct == F_JR)
              | (funct[5:3] == 3'b100)
              | (funct == 6'h2A) | (funct == 6'h2B);
  assign kill = d_bad;
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_R;
    shamt_sel  = 1'b0;
    link       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    jump       = 1'b0;
    size       = 2'b00;
    sign_ext   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
`ifdef CTRL_ILLEGAL_EN
    d_bad      = 1'b0;
`endif
    unique case (1'b1)
      is_r: begin
`ifdef CTRL_ILLEGAL_EN
        d_bad   = ~r_ok;
`endif
        reg_dst = 1'b1;
        if (funct == F_JR) begin
          jump = 1'b1;
        end else begin
          reg_write = 1'b1;
          shamt_sel = (funct == 6'h00)
                    | (funct == 6'h02)
                    | (funct == 6'h03);
        end
      end
      is_alui: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        unique case (op)
          6'h0A:   alu_op = ALU_SLT;
          6'h0C:   alu_op = ALU_AND;
          6'h0D:   alu_op = ALU_OR;
          6'h0E:   alu_op = ALU_XOR;
          6'h0F:   alu_op = ALU_LUI;
          default: alu_op = ALU_ADD;
        endcase
      end
      is_ld: begin
        alu_src    = 1'b1;
        alu_op     = ALU_ADD;
        mem_read   = 1'b1;
        size       = op[1:0];
        sign_ext   = ~op[2];
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      is_st: begin
        alu_src   = 1'b1;
        alu_op    = ALU_ADD;
        mem_write = 1'b1;
        size      = op[1:0];
      end
      is_br: begin
        alu_op = ALU_SUB;
        beq    = ~op[0];
        bne    = op[0];
      end
      is_j: begin
        jump = 1'b1;
      end
      is_jal: begin
        jump      = 1'b1;
        link      = 1'b1;
        reg_write = 1'b1;
      end
      default: begin
`ifdef CTRL_ILLEGAL_EN
        d_bad = 1'b1;
`endif
      end
    endcase
  end

  logic [NB_EX-1:0]   d_ex;
  logic [NB_MEM-1:0]  d_mem;
  logic [NB_WB-1:0]   d_wb;
  logic [NB_DATA-1:0] d_imm;
  logic               d_take;

  assign d_ex  = {reg_dst, alu_src, alu_op,
                  shamt_sel, link};
  assign d_mem = {mem_read, mem_write, beq, bne,
                  jump, size, sign_ext, 1'b0};
  assign d_wb  = {reg_write, mem_to_reg};
  assign d_imm = zext
               ? {{(NB_DATA-16){1'b0}}, imm16}
               : {{(NB_DATA-16){imm16[15]}}, imm16};
  assign d_take = in_valid & ~kill;

  // rt of the consumer only matters when it is read as a source
  assign out_stall = ~in_hold & in_valid & out_valid
                   & out_mem[NB_MEM-1] & (|out_rt)
                   & ((out_rt == rs)
                     | (uses_rt & (out_rt == rt)));

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_valid <= 1'b0;
      out_ex    <= '0;
      out_mem   <= '0;
      out_wb    <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_rd    <= '0;
      out_imm   <= '0;
      out_shamt <= '0;
`ifdef CTRL_ILLEGAL_EN
      out_illegal <= 1'b0;
`endif
    end else if (in_flush || (!in_hold && out_stall)) begin
      out_valid <= 1'b0;
      out_ex    <= '0;
      out_mem   <= '0;
      out_wb    <= '0;
`ifdef CTRL_ILLEGAL_EN
      out_illegal <= 1'b0;
`endif
    end else if (!in_hold) begin
      out_valid <= in_valid;
      out_ex    <= d_take ? d_ex  : '0;
      out_mem   <= d_take ? d_mem : '0;
      out_wb    <= d_take ? d_wb  : '0;
      out_rs    <= rs;
      out_rt    <= rt;
      out_rd    <= rd;
      out_imm   <= d_imm;
      out_shamt <= shamt;
`ifdef CTRL_ILLEGAL_EN
      out_illegal <= in_valid & kill;
`endif
    end
  end

endmodule

// File: tb/tb_control_id_pipe.sv
// tb_control_id_pipe: directed vector table plus hazard, hold,
// flush and reset sequences for control_id_pipe.
module tb_control_id_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = '0;
  logic        vld = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic        ovld;
  logic [7:0]  ex;
  logic [8:0]  mem;
  logic [1:0]  wb;
  logic [4:0]  rs, rt, rd, sh;
  logic [31:0] imm;
`ifdef CTRL_ILLEGAL_EN
  logic        ill;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_id_pipe dut (
    .in_clock       (clk),
    .in_reset_n     (rst_n),
    .in_instruction (ins),
    .in_valid       (vld),
    .in_hold        (hold),
    .in_flush       (flush),
    .out_stall      (stall),
    .out_valid      (ovld),
    .out_ex         (ex),
    .out_mem        (mem),
    .out_wb         (wb),
    .out_rs         (rs),
    .out_rt         (rt),
    .out_rd         (rd),
    .out_imm        (imm),
`ifdef CTRL_ILLEGAL_EN
    .out_illegal    (ill),
`endif
    .out_shamt      (sh)
  );

  typedef struct {
    logic [31:0] ins;
    logic        vld;
    logic [7:0]  ex;
    logic [8:0]  mem;
    logic [1:0]  wb;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic        ov;
    logic        ill;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i,
                       input logic v);
    ins = i;
    vld = v;
    #1;
  endtask

  initial begin
    tv[0]  = '{32'h8C200000, 1, 8'h44, 9'h10E, 2'b11,
               1, 0, 0, 0, 32'h0, 1, 0};
    tv[1]  = '{32'h22D5FFCE, 1, 8'h44, 9'h000, 2'b10,
               22, 21, 31, 31, 32'hFFFFFFCE, 1, 0};
    tv[2]  = '{32'h012A4020, 1, 8'h80, 9'h000, 2'b10,
               9, 10, 8, 0, 32'h00004020, 1, 0};
    tv[3]  = '{32'h1243A820, 1, 8'h1C, 9'h040, 2'b00,
               18, 3, 21, 0, 32'hFFFFA820, 1, 0};
    tv[4]  = '{32'h30448001, 1, 8'h48, 9'h000, 2'b10,
               2, 4, 16, 0, 32'h00008001, 1, 0};
    tv[5]  = '{32'hA0A6FFFC, 1, 8'h44, 9'h080, 2'b00,
               5, 6, 31, 31, 32'hFFFFFFFC, 1, 0};
    tv[6]  = '{32'h94E90010, 1, 8'h44, 9'h104, 2'b11,
               7, 9, 0, 0, 32'h00000010, 1, 0};
    tv[7]  = '{32'h0C000010, 1, 8'h01, 9'h010, 2'b10,
               0, 0, 0, 0, 32'h00000010, 1, 0};
    tv[8]  = '{32'h03E00008, 1, 8'h80, 9'h010, 2'b00,
               31, 0, 0, 0, 32'h00000008, 1, 0};
    tv[9]  = '{32'h00031100, 1, 8'h82, 9'h000, 2'b10,
               0, 3, 2, 4, 32'h00001100, 1, 0};
    tv[10] = '{32'hFC000000, 1, 8'h00, 9'h000, 2'b00,
               0, 0, 0, 0, 32'h0, 1, 1};
    tv[11] = '{32'h8C200000, 0, 8'h00, 9'h000, 2'b00,
               1, 0, 0, 0, 32'h0, 0, 0};
    tv[12] = '{32'h3C011234, 1, 8'h58, 9'h000, 2'b10,
               0, 1, 2, 8, 32'h00001234, 1, 0};

    #2;
    chk("rst_valid", 64'(ovld), 64'd0);
    chk("rst_mem", 64'(mem), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tv[i].ins, tv[i].vld);
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'd0);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(ovld), 64'(tv[i].ov));
      chk($sformatf("v%0d_ex", i), 64'(ex), 64'(tv[i].ex));
      chk($sformatf("v%0d_mem", i), 64'(mem), 64'(tv[i].mem));
      chk($sformatf("v%0d_wb", i), 64'(wb), 64'(tv[i].wb));
      chk($sformatf("v%0d_rs", i), 64'(rs), 64'(tv[i].rs));
      chk($sformatf("v%0d_rt", i), 64'(rt), 64'(tv[i].rt));
      chk($sformatf("v%0d_rd", i), 64'(rd), 64'(tv[i].rd));
      chk($sformatf("v%0d_sh", i), 64'(sh), 64'(tv[i].sh));
      chk($sformatf("v%0d_imm", i), 64'(imm), 64'(tv[i].imm));
`ifdef CTRL_ILLEGAL_EN
      chk($sformatf("v%0d_ill", i), 64'(ill), 64'(tv[i].ill));
`endif
    end

    // load-use: lw $3 then beq reading $3
    drive(32'h8C230000, 1'b1);
    tick();
    drive(32'h1243A820, 1'b1);
    chk("lu_stall", 64'(stall), 64'd1);
    tick();
    chk("lu_bub_valid", 64'(ovld), 64'd0);
    chk("lu_bub_mem", 64'(mem), 64'd0);
    chk("lu_bub_ex", 64'(ex), 64'd0);
    chk("lu_stall_drop", 64'(stall), 64'd0);
    tick();
    chk("lu_valid", 64'(ovld), 64'd1);
    chk("lu_ex", 64'(ex), 64'h1C);
    chk("lu_rs", 64'(rs), 64'd18);

    // same hazard under hold: no stall, registers frozen
    drive(32'h8C230000, 1'b1);
    tick();
    hold = 1'b1;
    drive(32'h1243A820, 1'b1);
    chk("hold_stall", 64'(stall), 64'd0);
    tick();
    tick();
    chk("hold_valid", 64'(ovld), 64'd1);
    chk("hold_mem", 64'(mem), 64'h10E);
    chk("hold_rt", 64'(rt), 64'd3);
    chk("hold_rs", 64'(rs), 64'd1);
    hold = 1'b0;
    #1;
    chk("unhold_stall", 64'(stall), 64'd1);

    // flush coinciding with stall: stall visible, flush wins
    flush = 1'b1;
    #1;
    chk("fl_stall", 64'(stall), 64'd1);
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(ovld), 64'd0);
    chk("fl_mem", 64'(mem), 64'd0);
    chk("fl_wb", 64'(wb), 64'd0);

    // plain flush with lw present
    drive(32'h8C230000, 1'b1);
    tick();
    flush = 1'b1;
    drive(32'h012A4020, 1'b1);
    tick();
    flush = 1'b0;
    chk("fl2_valid", 64'(ovld), 64'd0);
    chk("fl2_ex", 64'(ex), 64'd0);
    chk("fl2_mem", 64'(mem), 64'd0);

    // asynchronous reset while holding
    drive(32'h22D5FFCE, 1'b1);
    tick();
    hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(ovld), 64'd0);
    chk("ar_ex", 64'(ex), 64'd0);
    chk("ar_imm", 64'(imm), 64'd0);
    chk("ar_rt", 64'(rt), 64'd0);
    tick();
    rst_n = 1'b1;
    hold = 1'b0;
    drive(32'h012A4020, 1'b1);
    tick();
    chk("post_rst_rd", 64'(rd), 64'd8);
    chk("post_rst_valid", 64'(ovld), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
